// File: rtl/rsp_s2_dma_ahbic_pkg.sv
// Shared constants for the DMA AHB interconnect decoder/mux: address map,
// HRESP encodings and default-slave state encoding.
package rsp_s2_dma_ahbic_pkg;

   localparam int unsigned NUM_REGIONS = 4;

   // Element i describes slave i.
   localparam logic [NUM_REGIONS-1:0][31:0] REGION_BASE = {
      32'h4000_1000,
      32'h4000_0000,
      32'h0001_0000,
      32'h0000_0000
   };

   localparam logic [NUM_REGIONS-1:0][31:0] REGION_LIMIT = {
      32'h4000_1FFF,
      32'h4000_0FFF,
      32'h0001_FFFF,
      32'h0000_FFFF
   };

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      DS_IDLE = 2'd0,
      DS_ERR1 = 2'd1,
      DS_ERR2 = 2'd2
   } ds_state_t;

   // Offset compare keeps a zero base from collapsing into a constant test.
   function automatic logic in_region(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] limit);
      return (addr - base) <= (limit - base);
   endfunction

endpackage

// File: rtl/rsp_s2_dma_ahbic_addr_dec.sv
// Combinational HADDR decoder: one-hot slave hit, top bit set when no region
// matches (default slave).
module rsp_s2_dma_ahbic_addr_dec
   import rsp_s2_dma_ahbic_pkg::*;
#(
   parameter int NUM_SLV = 4
) (
   input  logic [31:0]      HADDR,
   output logic [NUM_SLV:0] dec
);

   logic [NUM_SLV-1:0] hit;

   for (genvar g = 0; g < NUM_SLV; g++) begin : g_region
      assign hit[g] = in_region(HADDR, REGION_BASE[g], REGION_LIMIT[g]);
   end

   assign dec = {~|hit, hit};

endmodule

// File: rtl/rsp_s2_dma_ahbic_dec_mux.sv
// AHB address decoder and response mux for the DMA interconnect, with an
// internal default slave that answers unmapped transfers with a two-cycle ERROR.
//
// state   | meaning
// DS_IDLE | no error in progress; default slave answers ready/OKAY
// DS_ERR1 | first ERROR cycle, HREADY low
// DS_ERR2 | second ERROR cycle, HREADY high; next address phase is sampled
module rsp_s2_dma_ahbic_dec_mux
   import rsp_s2_dma_ahbic_pkg::*;
#(
   parameter int NUM_SLV = 4,
   parameter int DW      = 32
) (
   input  logic                   HCLK,
   input  logic                   HRESET,
   input  logic [31:0]            HADDR,
   input  logic [1:0]             HTRANS,
   output logic [NUM_SLV-1:0]     HSEL_S,
   input  logic [NUM_SLV-1:0]     HREADYOUT_S,
   input  logic [2*NUM_SLV-1:0]   HRESP_S,
   input  logic [DW*NUM_SLV-1:0]  HRDATA_S,
   output logic                   HREADY,
   output logic [1:0]             HRESP,
   output logic [DW-1:0]          HRDATA,
   input  logic                   ERR_CLR,
   output logic [15:0]            ERR_CNT
);

   localparam logic [NUM_SLV:0] DSEL_DEFAULT = {1'b1, {NUM_SLV{1'b0}}};

   logic [NUM_SLV:0] dec;
   logic [NUM_SLV:0] dsel_q;
   ds_state_t        ds_state_q;
   ds_state_t        ds_state_d;
   logic             ds_hready;
   logic [1:0]       ds_hresp;
   logic             unmapped_req;
   logic             err_entry;
   logic [15:0]      err_cnt_q;
   logic             unused_htrans0;

   logic [NUM_SLV:0][1:0]    rsp_acc;
   logic [NUM_SLV:0][DW-1:0] dat_acc;

   assign unused_htrans0 = HTRANS[0];

   rsp_s2_dma_ahbic_addr_dec #(
      .NUM_SLV (NUM_SLV)
   ) u_addr_dec (
      .HADDR (HADDR),
      .dec   (dec)
   );

   assign HSEL_S = dec[NUM_SLV-1:0];

   always_comb begin
      ds_hready = 1'b1;
      ds_hresp  = HRESP_OKAY;
      case (ds_state_q)
         DS_ERR1: begin
            ds_hready = 1'b0;
            ds_hresp  = HRESP_ERROR;
         end
         DS_ERR2: ds_hresp = HRESP_ERROR;
         default: ;
      endcase
   end

   // dsel is one-hot, so the response mux is an AND-OR chain.
   assign rsp_acc[0] = dsel_q[NUM_SLV] ? ds_hresp : HRESP_OKAY;
   assign dat_acc[0] = '0;

   for (genvar g = 0; g < NUM_SLV; g++) begin : g_mux
      assign rsp_acc[g+1] = rsp_acc[g] | (dsel_q[g] ? HRESP_S[2*g +: 2] : 2'b00);
      assign dat_acc[g+1] = dat_acc[g] | (dsel_q[g] ? HRDATA_S[DW*g +: DW] : '0);
   end

   assign HREADY = (|(dsel_q[NUM_SLV-1:0] & HREADYOUT_S)) | (dsel_q[NUM_SLV] & ds_hready);
   assign HRESP  = rsp_acc[NUM_SLV];
   assign HRDATA = dat_acc[NUM_SLV];

   assign unmapped_req = HREADY & dec[NUM_SLV] & HTRANS[1];

   always_comb begin
      ds_state_d = ds_state_q;
      case (ds_state_q)
         DS_IDLE: if (unmapped_req) ds_state_d = DS_ERR1;
         DS_ERR1: ds_state_d = DS_ERR2;
         DS_ERR2: ds_state_d = unmapped_req ? DS_ERR1 : DS_IDLE;
         default: ds_state_d = DS_IDLE;
      endcase
   end

   assign err_entry = (ds_state_d == DS_ERR1);

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         dsel_q     <= DSEL_DEFAULT;
         ds_state_q <= DS_IDLE;
         err_cnt_q  <= '0;
      end else begin
         if (HREADY) dsel_q <= dec;
         ds_state_q <= ds_state_d;
         if (ERR_CLR)
            err_cnt_q <= '0;
         else if (err_entry && (err_cnt_q != ERR_CNT_MAX))
            err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_rsp_s2_dma_ahbic_dec_mux.sv
// Self-checking bench for rsp_s2_dma_ahbic_dec_mux: directed scenarios then
// random traffic, all compared against a transfer-level reference model.
module tb_rsp_s2_dma_ahbic_dec_mux;

   localparam int NUM_SLV = 4;
   localparam int DW      = 32;

   logic                  HCLK = 1'b0;
   logic                  HRESET;
   logic [31:0]           HADDR;
   logic [1:0]            HTRANS;
   logic [NUM_SLV-1:0]    HSEL_S;
   logic [NUM_SLV-1:0]    HREADYOUT_S;
   logic [2*NUM_SLV-1:0]  HRESP_S;
   logic [DW*NUM_SLV-1:0] HRDATA_S;
   logic                  HREADY;
   logic [1:0]            HRESP;
   logic [DW-1:0]         HRDATA;
   logic                  ERR_CLR;
   logic [15:0]           ERR_CNT;

   always #5 HCLK = ~HCLK;

   rsp_s2_dma_ahbic_dec_mux #(.NUM_SLV(NUM_SLV), .DW(DW)) dut (
      .HCLK        (HCLK),
      .HRESET      (HRESET),
      .HADDR       (HADDR),
      .HTRANS      (HTRANS),
      .HSEL_S      (HSEL_S),
      .HREADYOUT_S (HREADYOUT_S),
      .HRESP_S     (HRESP_S),
      .HRDATA_S    (HRDATA_S),
      .HREADY      (HREADY),
      .HRESP       (HRESP),
      .HRDATA      (HRDATA),
      .ERR_CLR     (ERR_CLR),
      .ERR_CNT     (ERR_CNT)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: target of the transfer currently in data phase
   // (0..3 slave, 4 default), cycle index of an error response (0 none,
   // 1 first, 2 second) and the error count.
   int          m_tgt;
   int          m_phase;
   logic [15:0] m_cnt;
   logic        m_rdy;

   function automatic int ref_decode(input logic [31:0] a);
      if (a <= 32'h0000_FFFF) return 0;
      if (a >= 32'h0001_0000 && a <= 32'h0001_FFFF) return 1;
      if (a >= 32'h4000_0000 && a <= 32'h4000_0FFF) return 2;
      if (a >= 32'h4000_1000 && a <= 32'h4000_1FFF) return 3;
      return 4;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      int          d;
      logic        er;
      logic [1:0]  ep;
      logic [31:0] ed;
      #1;
      d = ref_decode(HADDR);
      if (m_tgt < 4) begin
         er = 1'(HREADYOUT_S >> m_tgt);
         ep = 2'(HRESP_S >> (2 * m_tgt));
         ed = 32'(HRDATA_S >> (DW * m_tgt));
      end else begin
         er = (m_phase != 1);
         ep = (m_phase == 0) ? 2'b00 : 2'b01;
         ed = 32'd0;
      end
      m_rdy = er;
      chk({tag, ":hsel"},   32'(HSEL_S),  (d < 4) ? (32'd1 << d) : 32'd0);
      chk({tag, ":hready"}, 32'(HREADY),  32'(er));
      chk({tag, ":hresp"},  32'(HRESP),   32'(ep));
      chk({tag, ":hrdata"}, 32'(HRDATA),  ed);
      chk({tag, ":errcnt"}, 32'(ERR_CNT), 32'(m_cnt));
   endtask

   task automatic adv();
      int   d;
      logic inc;
      inc = 1'b0;
      @(posedge HCLK);
      if (HRESET) begin
         m_tgt   = 4;
         m_phase = 0;
         m_cnt   = 16'd0;
      end else begin
         if (m_rdy) begin
            d     = ref_decode(HADDR);
            m_tgt = d;
            if (d == 4 && HTRANS[1]) begin
               m_phase = 1;
               inc     = 1'b1;
            end else begin
               m_phase = 0;
            end
         end else if (m_phase == 1) begin
            m_phase = 2;
         end
         if (ERR_CLR) m_cnt = 16'd0;
         else if (inc && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      @(negedge HCLK);
   endtask

   task automatic cyc(input string tag);
      check_model(tag);
      adv();
   endtask

   logic [31:0] bnd_addr [8];
   logic [3:0]  bnd_hsel [8];

   initial begin
      int sel;

      HRESET      = 1'b1;
      HADDR       = 32'h0;
      HTRANS      = 2'b00;
      HREADYOUT_S = '1;
      HRESP_S     = '0;
      HRDATA_S    = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
      ERR_CLR     = 1'b0;
      m_tgt       = 4;
      m_phase     = 0;
      m_cnt       = 16'd0;
      m_rdy       = 1'b1;

      repeat (2) @(negedge HCLK);
      HRESET = 1'b0;
      HADDR  = 32'h8000_0000;
      check_model("reset");
      chk("reset_hready", 32'(HREADY), 32'd1);
      chk("reset_hresp",  32'(HRESP),  32'd0);
      chk("reset_hrdata", HRDATA,      32'd0);
      chk("reset_errcnt", 32'(ERR_CNT), 32'd0);
      adv();

      // S1 zero-wait read
      HADDR  = 32'h0001_0004;
      HTRANS = 2'b10;
      check_model("s1_addr");
      chk("s1_hsel", 32'(HSEL_S), 32'b0010);
      adv();
      HADDR  = 32'h8000_0000;
      HTRANS = 2'b00;
      check_model("s1_data");
      chk("s1_hrdata", HRDATA,     32'hA5A5_0001);
      chk("s1_hresp",  32'(HRESP), 32'd0);
      adv();

      // Single unmapped NONSEQ
      HTRANS = 2'b10;
      cyc("unm_addr");
      HTRANS = 2'b00;
      check_model("unm_err1");
      chk("unm_err1_hready", 32'(HREADY), 32'd0);
      chk("unm_err1_hresp",  32'(HRESP),  32'd1);
      adv();
      check_model("unm_err2");
      chk("unm_err2_hready", 32'(HREADY),  32'd1);
      chk("unm_err2_hresp",  32'(HRESP),   32'd1);
      chk("unm_errcnt",      32'(ERR_CNT), 32'd1);
      adv();
      cyc("unm_idle");

      // Back-to-back unmapped NONSEQ after a counter clear
      ERR_CLR = 1'b1;
      cyc("clr");
      ERR_CLR = 1'b0;
      HADDR   = 32'h8000_0000;
      HTRANS  = 2'b10;
      cyc("b2b_addr0");
      HADDR = 32'h8000_0004;
      check_model("b2b_e1a");
      chk("b2b_e1a_hready", 32'(HREADY), 32'd0);
      adv();
      check_model("b2b_e2a");
      chk("b2b_e2a_hready", 32'(HREADY), 32'd1);
      chk("b2b_e2a_hresp",  32'(HRESP),  32'd1);
      adv();
      HTRANS = 2'b00;
      check_model("b2b_e1b");
      chk("b2b_e1b_hready", 32'(HREADY), 32'd0);
      chk("b2b_e1b_hresp",  32'(HRESP),  32'd1);
      adv();
      check_model("b2b_e2b");
      chk("b2b_e2b_hresp",  32'(HRESP),   32'd1);
      chk("b2b_errcnt",     32'(ERR_CNT), 32'd2);
      adv();
      cyc("b2b_idle");

      // S2 wait states while the next address targets S0
      HADDR  = 32'h4000_0000;
      HTRANS = 2'b10;
      cyc("s2_addr");
      HADDR       = 32'h0000_0000;
      HREADYOUT_S = 4'b1011;
      for (int i = 0; i < 3; i++) begin
         check_model("s2_wait");
         chk("s2_wait_hready", 32'(HREADY), 32'd0);
         chk("s2_wait_hsel",   32'(HSEL_S), 32'b0001);
         adv();
      end
      HREADYOUT_S = '1;
      check_model("s2_done");
      chk("s2_done_hrdata", HRDATA, 32'hA5A5_0002);
      adv();
      HTRANS = 2'b00;
      check_model("s0_data");
      chk("s0_data_hrdata", HRDATA, 32'hA5A5_0000);
      adv();

      // Region boundaries
      bnd_addr = '{32'h0000_FFFF, 32'h0001_0000, 32'h0001_FFFF, 32'h0002_0000,
                   32'h4000_0FFF, 32'h4000_1000, 32'h4000_1FFF, 32'h4000_2000};
      bnd_hsel = '{4'b0001, 4'b0010, 4'b0010, 4'b0000,
                   4'b0100, 4'b1000, 4'b1000, 4'b0000};
      for (int i = 0; i < 8; i++) begin
         HADDR = bnd_addr[i];
         check_model("bnd");
         chk("bnd_hsel", 32'(HSEL_S), 32'(bnd_hsel[i]));
         adv();
      end
      HADDR  = 32'h4000_2000;
      HTRANS = 2'b10;
      cyc("bnd_err_addr");
      HTRANS = 2'b00;
      check_model("bnd_err1");
      chk("bnd_err1_hresp", 32'(HRESP), 32'd1);
      adv();
      cyc("bnd_err2");

      // Clear wins over a coincident increment
      HADDR   = 32'h8000_0000;
      HTRANS  = 2'b10;
      ERR_CLR = 1'b1;
      cyc("clrinc_addr");
      ERR_CLR = 1'b0;
      HTRANS  = 2'b00;
      check_model("clrinc_e1");
      chk("clrinc_errcnt", 32'(ERR_CNT), 32'd0);
      adv();
      cyc("clrinc_e2");
      cyc("clrinc_idle");

      // Saturation
      force dut.err_cnt_q = 16'hFFFF;
      m_cnt = 16'hFFFF;
      cyc("sat_preload");
      release dut.err_cnt_q;
      HTRANS = 2'b10;
      cyc("sat_addr");
      HTRANS = 2'b00;
      check_model("sat_e1");
      chk("sat_errcnt", 32'(ERR_CNT), 32'h0000_FFFF);
      adv();
      cyc("sat_e2");

      // Reset inside DS_ERR1
      HTRANS = 2'b10;
      cyc("rst_err_addr");
      HTRANS = 2'b00;
      HRESET = 1'b1;
      cyc("rst_err_e1");
      HRESET = 1'b0;
      check_model("rst_err_after");
      chk("rst_err_hready", 32'(HREADY),  32'd1);
      chk("rst_err_hresp",  32'(HRESP),   32'd0);
      chk("rst_err_errcnt", 32'(ERR_CNT), 32'd0);
      adv();

      // Reset during a slave wait
      HADDR  = 32'h0001_0000;
      HTRANS = 2'b10;
      cyc("rst_wait_addr");
      HREADYOUT_S = 4'b1101;
      HTRANS      = 2'b00;
      HRESET      = 1'b1;
      cyc("rst_wait_stall");
      HRESET = 1'b0;
      check_model("rst_wait_after");
      chk("rst_wait_hready", 32'(HREADY), 32'd1);
      chk("rst_wait_hrdata", HRDATA,      32'd0);
      adv();
      HREADYOUT_S = '1;

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         sel = int'($urandom_range(0, 6));
         case (sel)
            0: HADDR = 32'h0000_0000 + 32'($urandom_range(0, 32'hFFFF));
            1: HADDR = 32'h0001_0000 + 32'($urandom_range(0, 32'hFFFF));
            2: HADDR = 32'h4000_0000 + 32'($urandom_range(0, 32'hFFF));
            3: HADDR = 32'h4000_1000 + 32'($urandom_range(0, 32'hFFF));
            4: HADDR = 32'h8000_0000 | $urandom();
            5: HADDR = 32'h0002_0000 + 32'($urandom_range(0, 32'hFFFF));
            default: HADDR = 32'h4000_2000 + 32'($urandom_range(0, 32'hFFF));
         endcase
         HTRANS = 2'($urandom_range(0, 3));
         for (int s = 0; s < NUM_SLV; s++) begin
            HREADYOUT_S[s]       = ($urandom_range(0, 3) != 0);
            HRESP_S[2*s +: 2]    = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00;
            HRDATA_S[DW*s +: DW] = $urandom();
         end
         ERR_CLR = ($urandom_range(0, 15) == 0);
         HRESET  = ($urandom_range(0, 63) == 0);
         cyc("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
